// File: rtl/dac_jesd204_stream_buffer.sv
// dac_jesd204_stream_buffer
//   Elastic buffer and start/underflow controller in front of the JESD204 TX
//   framer. Source words arrive over valid/ready. After PREFILL words are
//   buffered, one word is released per tx_clk. Zeros are substituted on
//   underflow and for masked channels.
//
// Ports
//   tx_clk        lane clock; all logic is on this clock
//   tx_resetn     asynchronous active-low reset
//   enable        stream enable (level); low flushes the buffer
//   chan_enable   per-channel output mask (0 forces channel samples to zero)
//   s_valid       source word valid
//   s_ready       buffer can accept a word
//   s_data        source word, same sample ordering as dac_data
//   dac_data      framer sample bus; channel c at [c*DPW*16 +: DPW*16]
//   dac_valid     dac_data carries a real buffered word
//   underflow     sticky underflow flag
//   underflow_clr clears underflow (a set in the same cycle wins)
//   level         current FIFO occupancy, 0..D
module dac_jesd204_stream_buffer #(
    parameter int NUM_LANES       = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int PREFILL         = 4
) (
    input  logic                       tx_clk,
    input  logic                       tx_resetn,
    input  logic                       enable,
    input  logic [NUM_CHANNELS-1:0]    chan_enable,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_LANES*32-1:0]    s_data,
    output logic [NUM_LANES*32-1:0]    dac_data,
    output logic                       dac_valid,
    output logic                       underflow,
    input  logic                       underflow_clr,
    output logic [FIFO_ADDR_WIDTH:0]   level
);

    localparam int W   = NUM_LANES * 32;
    localparam int DPW = 2 * NUM_LANES / NUM_CHANNELS;
    localparam int CW  = DPW * 16;
    localparam int D   = 1 << FIFO_ADDR_WIDTH;
    localparam int LW  = FIFO_ADDR_WIDTH + 1;
    localparam logic [LW-1:0] D_LVL       = LW'(D);
    localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0]              level_q;
    logic [W-1:0]               mem [D];
    logic [W-1:0]               mask;
    logic                       wr_en, rd_en, uf_set;

    assign level   = level_q;
    // Derived from registered state/level only, so a full FIFO stays closed
    // in the cycle of a read; the freed slot is offered one cycle later.
    assign s_ready = (state_q != IDLE) && (level_q < D_LVL);
    assign wr_en   = s_valid && s_ready;

    always_comb begin
        mask = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            mask[c*CW +: CW] = {CW{chan_enable[c]}};
        end
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        uf_set  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = PRIME;
                PRIME: if (level_q >= PREFILL_LVL) state_d = RUN;
                RUN: begin
                    if (level_q == '0) begin
                        // Starved: flag it and re-prime before resuming.
                        state_d = PRIME;
                        uf_set  = 1'b1;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge tx_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (!enable) begin
            // Disable discards everything buffered.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            dac_data  <= '0;
            dac_valid <= 1'b0;
        end else if (rd_en) begin
            dac_data  <= mem[rd_ptr] & mask;
            dac_valid <= 1'b1;
        end else begin
            dac_data  <= '0;
            dac_valid <= 1'b0;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_jesd204_stream_buffer.sv
module tb_dac_jesd204_stream_buffer;

    logic         tx_clk = 1'b0;
    logic         tx_resetn;
    logic         enable, enable2;
    logic [3:0]   chan_enable;
    logic         s_valid, s_valid2;
    logic         s_ready, s_ready2;
    logic [255:0] s_data, s_data2;
    logic [255:0] dac_data, dac_data2;
    logic         dac_valid, dac_valid2;
    logic         underflow, underflow2;
    logic         underflow_clr;
    logic [3:0]   level, level2;

    int checks   = 0;
    int failures = 0;

    dac_jesd204_stream_buffer #(
        .NUM_LANES(8), .NUM_CHANNELS(4), .FIFO_ADDR_WIDTH(3), .PREFILL(4)
    ) dut (
        .tx_clk(tx_clk), .tx_resetn(tx_resetn), .enable(enable),
        .chan_enable(chan_enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .dac_data(dac_data), .dac_valid(dac_valid),
        .underflow(underflow), .underflow_clr(underflow_clr), .level(level)
    );

    dac_jesd204_stream_buffer #(
        .NUM_LANES(8), .NUM_CHANNELS(4), .FIFO_ADDR_WIDTH(3), .PREFILL(8)
    ) dut2 (
        .tx_clk(tx_clk), .tx_resetn(tx_resetn), .enable(enable2),
        .chan_enable(chan_enable), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_data(s_data2), .dac_data(dac_data2), .dac_valid(dac_valid2),
        .underflow(underflow2), .underflow_clr(underflow_clr), .level(level2)
    );

    always #5 tx_clk = ~tx_clk;

    function automatic logic [255:0] wa(input int k);
        return {8{32'hA500_0000 | 32'(k)}};
    endfunction

    function automatic logic [255:0] wb(input int k);
        return {8{32'hB700_0000 | 32'(k)}};
    endfunction

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [255:0] masked;
    int n, nexp;
    logic acc;

    initial begin
        tx_resetn = 1'b1; enable = 1'b0; enable2 = 1'b0; chan_enable = 4'hF;
        s_valid = 1'b0; s_valid2 = 1'b0; s_data = '0; s_data2 = '0;
        underflow_clr = 1'b0;
        #3 tx_resetn = 1'b0;
        #1;
        check("rst_s_ready", 256'(s_ready), 256'(0));
        check("rst_dac_data", dac_data, '0);
        check("rst_dac_valid", 256'(dac_valid), 256'(0));
        check("rst_underflow", 256'(underflow), 256'(0));
        check("rst_level", 256'(level), 256'(0));
        tick(); tick();
        tx_resetn = 1'b1;
        tick();
        check("idle_s_ready", 256'(s_ready), 256'(0));

        // Prime with 4 words, then stream them out.
        enable = 1'b1;
        tick();
        check("prime_s_ready", 256'(s_ready), 256'(1));
        s_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s_data = wa(k);
            tick();
        end
        s_valid = 1'b0;
        check("prime_level4", 256'(level), 256'(4));
        check("prime_no_valid", 256'(dac_valid), 256'(0));
        tick();
        check("latency_no_valid", 256'(dac_valid), 256'(0));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("run_valid", 256'(dac_valid), 256'(1));
            check("run_data", dac_data, wa(k));
        end
        tick();
        check("uf_valid0", 256'(dac_valid), 256'(0));
        check("uf_data0", dac_data, '0);
        check("uf_set", 256'(underflow), 256'(1));
        check("uf_reprime_ready", 256'(s_ready), 256'(1));

        // Resupply; clear the flag while re-priming.
        s_valid = 1'b1; underflow_clr = 1'b1;
        s_data = wa(5);
        tick();
        underflow_clr = 1'b0;
        check("uf_cleared", 256'(underflow), 256'(0));
        for (int k = 6; k <= 8; k++) begin
            s_data = wa(k);
            tick();
        end
        s_valid = 1'b0;
        tick();
        for (int k = 5; k <= 8; k++) begin
            tick();
            check("restart_data", dac_data, wa(k));
        end
        underflow_clr = 1'b1;
        tick();
        check("uf_set_beats_clr", 256'(underflow), 256'(1));
        tick();
        check("uf_clr_later", 256'(underflow), 256'(0));
        underflow_clr = 1'b0;

        // Channel mask with level held at 5 in RUN.
        chan_enable = 4'b1011;
        s_valid = 1'b1; s_data = '1;
        for (int k = 0; k < 6; k++) tick();
        masked = '1;
        masked[191:128] = '0;
        check("mask_level5", 256'(level), 256'(5));
        check("mask_valid", 256'(dac_valid), 256'(1));
        check("mask_data", dac_data, masked);

        // One-cycle disable flushes the buffer.
        enable = 1'b0; s_valid = 1'b0;
        tick();
        check("dis_valid", 256'(dac_valid), 256'(0));
        check("dis_data", dac_data, '0);
        check("dis_level", 256'(level), 256'(0));
        check("dis_s_ready", 256'(s_ready), 256'(0));
        chan_enable = 4'hF;
        enable = 1'b1;
        tick();
        check("reen_level", 256'(level), 256'(0));
        s_valid = 1'b1;
        for (int k = 9; k <= 12; k++) begin
            s_data = wa(k);
            tick();
        end
        s_valid = 1'b0;
        tick();
        for (int k = 9; k <= 12; k++) begin
            tick();
            check("reen_data", dac_data, wa(k));
        end
        tick();
        check("reen_uf", 256'(underflow), 256'(1));

        // PREFILL = D: fill to full with the reader stalled, then drain.
        enable2 = 1'b1;
        tick();
        n = 1; nexp = 1; s_valid2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data2 = wb(n);
            acc = s_ready2;
            tick();
            if (acc) n++;
        end
        check("full_count", 256'(n), 256'(9));
        check("full_level", 256'(level2), 256'(8));
        check("full_s_ready", 256'(s_ready2), 256'(0));
        for (int i = 0; i < 40; i++) begin
            s_valid2 = (n <= 16);
            s_data2 = wb(n);
            acc = s_ready2 && s_valid2;
            tick();
            if (acc) n++;
            if (dac_valid2) begin
                check("full_stream", dac_data2, wb(nexp));
                nexp++;
            end
        end
        s_valid2 = 1'b0;
        check("full_all_out", 256'(nexp), 256'(17));
        check("full_uf", 256'(underflow2), 256'(1));

        // Async reset mid-RUN with underflow set.
        s_valid = 1'b1;
        for (int k = 13; k <= 16; k++) begin
            s_data = wa(k);
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        check("pre_rst_valid", 256'(dac_valid), 256'(1));
        check("pre_rst_uf", 256'(underflow), 256'(1));
        #3 tx_resetn = 1'b0;
        #1;
        check("arst_valid", 256'(dac_valid), 256'(0));
        check("arst_data", dac_data, '0);
        check("arst_uf", 256'(underflow), 256'(0));
        check("arst_level", 256'(level), 256'(0));
        check("arst_s_ready", 256'(s_ready), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_jesd204_stream_buffer.md
Name: dac_jesd204_stream_buffer

Overview:
- Elastic buffer plus start/underflow controller that feeds the dac_data bus of the JESD204 TX framer stage.
- Accepts full-width sample words from the DMA/DDS mux over a valid/ready handshake and holds a small FIFO.
- Releases one word per tx_clk once primed, and substitutes zeros on underflow or for disabled channels.

Parameters:
- NUM_LANES, 8, JESD lanes; data width W = NUM_LANES*32.
- NUM_CHANNELS, 4, converter channels; each owns DPW = 2*NUM_LANES/NUM_CHANNELS 16-bit samples.
- FIFO_ADDR_WIDTH, 3, FIFO depth D = 2**FIFO_ADDR_WIDTH words.
- PREFILL, 4, words required before streaming starts or restarts; legal range 1..D.

Ports:
- tx_clk  in  1  lane clock (line-rate/40); all logic is on this clock.
- tx_resetn  in  1  asynchronous active-low reset.
- enable  in  1  stream enable (level).
- chan_enable  in  NUM_CHANNELS  per-channel output mask; 0 forces that channel's samples to zero.
- s_valid  in  1  source word valid.
- s_ready  out  1  buffer can accept a word.
- s_data  in  W  source word, same sample ordering as dac_data.
- dac_data  out  W  framer sample bus; channel c occupies bits [c*DPW*16 +: DPW*16].
- dac_valid  out  1  dac_data carries a real FIFO word this cycle.
- underflow  out  1  sticky underflow flag.
- underflow_clr  in  1  clears underflow.
- level  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy, 0..D.

Behaviour:
- Reset (tx_resetn=0, async assert, sync release):
  - state IDLE; read/write pointers 0; level 0.
  - s_ready 0, dac_data 0, dac_valid 0, underflow 0.
- FIFO:
  - Write when s_valid && s_ready; the word is counted in level the next cycle.
  - s_ready = (state != IDLE) && (level < D), derived from registered level. When full, writes are not accepted in the same cycle as a read; the slot frees one cycle later.
- States:
  - IDLE: s_ready=0; pointers held at 0. Any enable=0 cycle in any state forces IDLE next cycle, flushes pointers (level=0) and drives outputs to 0 / dac_valid 0. Mid-stream disable therefore discards buffered words.
  - IDLE -> PREFILL when enable=1.
  - PREFILL: writes accepted; no reads; dac_data=0, dac_valid=0. Go to RUN when level >= PREFILL, evaluated on registered level.
  - RUN: one read per cycle while level>0.
    - Read in cycle r: dac_data updates at the r+1 edge (one-cycle registered latency) with dac_valid=1.
    - If level==0 in RUN: no read; next dac_data=0, dac_valid=0; underflow set; state -> PREFILL (re-prime before resuming).
- Simultaneous read and write in RUN: level unchanged; pointers both advance and wrap modulo D.
- Channel mask: applied in the output register, using chan_enable sampled in the read cycle. A disabled channel's DPW samples are 0 even when dac_valid=1.
- underflow: set has priority over underflow_clr in the same cycle; otherwise underflow_clr=1 clears it next cycle. Not cleared by enable.
- Sample bit order is passed through unchanged; byte/octet placement is the framer's job.

Test Plan:
- Reset, then enable=1, write 4 words 0x..01..0x..04 back-to-back -> PREFILL until level=4; dac_data=word1 with dac_valid=1 exactly two cycles after the 4th write; words 1..4 follow on consecutive cycles.
- Source stalls after 4 words with PREFILL=4 -> after word 4, dac_data=0, dac_valid=0, underflow=1. Resupply 4 words -> restarts in order. Pulse underflow_clr -> underflow=0.
- enable=1, source continuously valid with the reader stalled (PREFILL=D=8) -> level reaches 8, s_ready=0; no word lost or duplicated once RUN drains.
- chan_enable=4'b1011, NUM_CHANNELS=4, DPW=4, all-ones words -> bits [191:128] of dac_data =0, rest all-ones, dac_valid=1.
- In RUN with level=5, drop enable for one cycle -> next cycle dac_valid=0, dac_data=0, level=0, s_ready=0. Re-enable -> fresh PREFILL; no stale words appear.
- Assert tx_resetn=0 asynchronously mid-RUN with underflow=1 -> all outputs 0 immediately without waiting for a clock edge; level=0.
